// File: rtl/tap_sequence_decoder.sv
// Groups press pulses separated by at most GAP_CYCLES edges into one burst and
// reports the tap count of each completed burst with a one-cycle strobe.
module tap_sequence_decoder #(
  parameter int GAP_CYCLES = 50,
  parameter int CNT_W      = 3,
  parameter int MAX_TAPS   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             press,
  input  logic             clear,
  output logic [CNT_W-1:0] tap_count,
  output logic             tap_valid,
  output logic             busy
);

  localparam int TMR_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_TAPS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, COUNT, EMIT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [TMR_W-1:0] tmr, tmr_nx;
  logic [CNT_W-1:0] tap_count_nx;
  logic             tap_valid_nx;
  logic             busy_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tmr       <= '0;
      tap_count <= '0;
      tap_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      tmr       <= tmr_nx;
      tap_count <= tap_count_nx;
      tap_valid <= tap_valid_nx;
      busy      <= busy_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    tmr_nx       = tmr;
    tap_count_nx = tap_count;
    tap_valid_nx = 1'b0;

    case (state)
      IDLE: begin
        if (press) begin
          state_nx = COUNT;
          cnt_nx   = CNT_ONE;
          tmr_nx   = '0;
        end
      end
      COUNT: begin
        // A press always restarts the gap timer, even once the count saturates.
        if (press) begin
          cnt_nx = sat_inc(cnt);
          tmr_nx = '0;
        end else if (tmr == TMR_LAST) begin
          state_nx     = EMIT;
          tap_count_nx = cnt;
          tap_valid_nx = 1'b1;
        end else begin
          tmr_nx = tmr + TMR_W'(1);
        end
      end
      EMIT: begin
        // A press arriving on the strobe cycle opens the next burst.
        if (press) begin
          state_nx = COUNT;
          cnt_nx   = CNT_ONE;
          tmr_nx   = '0;
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
          tmr_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        tmr_nx   = '0;
      end
    endcase

    if (clear) begin
      state_nx     = IDLE;
      cnt_nx       = '0;
      tmr_nx       = '0;
      tap_count_nx = tap_count;
      tap_valid_nx = 1'b0;
    end

    busy_nx = (state_nx == COUNT);
  end

endmodule

// File: tb/tb_tap_sequence_decoder.sv
// Directed bench for tap_sequence_decoder with GAP_CYCLES=4, MAX_TAPS=7.
module tb_tap_sequence_decoder;

  localparam int GAP   = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             reset;
  logic             press;
  logic             clear;
  logic [CNT_W-1:0] tap_count;
  logic             tap_valid;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  tap_sequence_decoder #(
    .GAP_CYCLES(GAP),
    .CNT_W     (CNT_W),
    .MAX_TAPS  (7)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .press    (press),
    .clear    (clear),
    .tap_count(tap_count),
    .tap_valid(tap_valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] b(input int e);
    return 64'(1) << e;
  endfunction

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m |= 64'(1) << i;
    return m;
  endfunction

  // Edge e: press/clear bits are sampled at edge e, outputs checked 1 time unit later.
  task automatic play(input string tag, input int n,
                      input logic [63:0] pm, input logic [63:0] cm,
                      input logic [63:0] vm, input logic [63:0] bm,
                      input int ca, input int cb);
    int ns;
    ns = 0;
    for (int e = 0; e < n; e++) begin
      press = pm[e];
      clear = cm[e];
      @(posedge clk);
      #1;
      press = 1'b0;
      clear = 1'b0;
      chk($sformatf("%s.valid@%0d", tag, e), int'(tap_valid), int'(vm[e]));
      chk($sformatf("%s.busy@%0d", tag, e), int'(busy), int'(bm[e]));
      if (vm[e]) begin
        chk($sformatf("%s.count@%0d", tag, e), int'(tap_count), (ns == 0) ? ca : cb);
        ns++;
      end
    end
  endtask

  logic [63:0] sat_pm;

  initial begin
    press = 1'b0;
    clear = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_async.valid", int'(tap_valid), 0);
    chk("rst_async.count", int'(tap_count), 0);
    chk("rst_async.busy",  int'(busy), 0);

    for (int i = 0; i < 4; i++) begin
      press = i[0];
      @(posedge clk);
      #1;
      chk("rst_hold.valid", int'(tap_valid), 0);
      chk("rst_hold.busy",  int'(busy), 0);
    end
    press = 1'b0;
    reset = 1'b1;
    play("idle", 20, '0, '0, '0, '0, 0, 0);
    chk("idle.count", int'(tap_count), 0);

    play("single", 7, b(0), '0, b(4), rng(0, 3), 1, 1);
    play("triple", 15, b(0) | b(4) | b(8), '0, b(12), rng(0, 11), 3, 3);
    play("split", 12, b(0) | b(5), '0, b(4) | b(9), rng(0, 3) | rng(5, 8), 1, 1);
    play("emit_press", 13, b(0) | b(2) | b(7), '0, b(6) | b(11),
         rng(0, 5) | rng(7, 10), 2, 1);

    sat_pm = '0;
    for (int i = 0; i < 9; i++) sat_pm |= b(2 * i);
    play("sat", 22, sat_pm, '0, b(20), rng(0, 19), 7, 7);
    play("held", 16, rng(0, 9), '0, b(13), rng(0, 12), 7, 7);

    play("pre_clear", 8, b(0) | b(2), '0, b(6), rng(0, 5), 2, 2);
    play("clear", 10, b(0) | b(2) | b(3), b(3), '0, rng(0, 2), 0, 0);
    chk("clear.count_held", int'(tap_count), 2);

    play("pre_rst", 3, b(0) | b(2), '0, '0, rng(0, 2), 0, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst.count", int'(tap_count), 0);
    chk("mid_rst.busy",  int'(busy), 0);
    chk("mid_rst.valid", int'(tap_valid), 0);
    reset = 1'b1;
    play("post_rst", 8, '0, '0, '0, '0, 0, 0);
    chk("post_rst.count", int'(tap_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tap_sequence_decoder.md
Name: tap_sequence_decoder

Overview:
- Sits directly downstream of the pushbutton detector, in the same divided-clock domain.
- Consumes its single-cycle press pulses and groups pulses closer together than a programmable gap into one burst.
- When the burst ends, emits a one-cycle valid strobe with the tap count (single/double/triple tap, etc.).
- Feeds mode/menu control logic, which acts on tap_count when tap_valid is high.

Parameters:
- GAP_CYCLES, default 50: max clock edges between press sampling edges for presses to be in the same burst; also the idle time that closes a burst. Legal range ≥2.
- CNT_W, default 3: width of tap_count.
- MAX_TAPS, default 7: saturation value of the count; must be ≤ 2^CNT_W − 1.

Ports:
- clk  in  1  block clock (same clock as the detector output).
- reset  in  1  asynchronous, active-low reset.
- press  in  1  single-cycle press pulse from the detector.
- clear  in  1  synchronous abort of the current burst, active-high.
- tap_count  out  CNT_W  tap count of the most recently completed burst; held between emissions.
- tap_valid  out  1  one-cycle strobe: tap_count updated this cycle.
- busy  out  1  high while a burst is being collected.

Behaviour:
- Reset (reset=0, async): state IDLE, internal count=0, timer=0, tap_count=0, tap_valid=0, busy=0. Outputs settle without a clock edge.
- All outputs are registered.
- Timer width: clog2(GAP_CYCLES).
- FSM states: IDLE, COUNT, EMIT.

- IDLE:
  - press=1 → COUNT; count=1; timer=0.
  - Otherwise stay in IDLE.

- COUNT (busy=1):
  - press=1 → count=min(count+1, MAX_TAPS); timer=0.
  - press=0 and timer<GAP_CYCLES−1 → timer+1.
  - press=0 and timer==GAP_CYCLES−1 → EMIT; tap_count←count; tap_valid←1.
  - Consequence: press pulses whose sampling edges are ≤GAP_CYCLES apart join the same burst; GAP_CYCLES+1 or more apart start a new burst.

- EMIT (tap_valid=1 for exactly one cycle, busy=0):
  - Next edge clears tap_valid.
  - press=1 at that edge → COUNT with count=1, timer=0. The press is not lost.
  - Otherwise → IDLE.

- Latency: tap_valid is high during the cycle after the GAP_CYCLES-th edge following the edge that sampled the last press.

- Saturation: count never exceeds MAX_TAPS. Further presses still restart the timer.

- press held high (protocol violation): each high cycle counts as one press (saturating). The burst ends only after press has been low for GAP_CYCLES edges.

- clear=1 (highest priority after reset), in any state: → IDLE; count=0; timer=0; tap_valid=0.
  - No emission for the aborted burst.
  - tap_count keeps its last emitted value.
  - A press in the same cycle as clear is ignored.

- reset asserted mid-burst: immediate return to reset values; no emission.
- tap_valid is never high in two consecutive cycles.

Test Plan:
- Reset: drive reset=0 with press toggling → tap_valid=0, tap_count=0, busy=0. After reset=1 with press=0 for 20 cycles, outputs are unchanged.
- Single tap (GAP_CYCLES=4): press at edge 0 → busy=1 after edge 0. After edge 4: tap_valid=1, tap_count=1, busy=0. tap_valid=0 after edge 5.
- Triple tap (GAP_CYCLES=4): presses at edges 0, 4, 8 → exactly one strobe after edge 12, tap_count=3. Presses at edges 0 and 5 → two strobes, after edges 4 and 9, each with tap_count=1.
- Saturation (GAP_CYCLES=4, MAX_TAPS=7): 9 presses every 2 edges → single strobe with tap_count=7, 4 edges after the 9th press.
- Press during EMIT (GAP_CYCLES=4): press at edge 0, then press at edge 5 (EMIT exit) → strobe after edge 4 with count=1. Second burst with count=1 strobes after edge 9.
- Abort: complete one burst of 2, then press at 0 and 2 with clear=1 at edge 3 → no strobe, busy=0, tap_count stays 2. Repeat with reset pulsed low at edge 3 → no strobe, tap_count=0.
